// File: rtl/spi_master_if.sv
// Register-port and SPI pin bundle for spi_master.
// The slave modport is the spi_master view; master is the core/board side.
interface spi_master_if;
    logic       wren;
    logic [7:0] data_i;
    logic       cs_n_i;
    logic [7:0] data_o;
    logic       dsr;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ss_n;

    modport master (
        output wren, data_i, cs_n_i, miso,
        input  data_o, dsr, sclk, mosi, ss_n
    );

    modport slave (
        input  wren, data_i, cs_n_i, miso,
        output data_o, dsr, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master behind the core's user register port.
// Define SPI_LSB_FIRST_EN to shift LSB first in both directions.
module spi_master #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    spi_master_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    state_t     state, state_next;
    logic [7:0] div, div_next;
    logic [2:0] bitcnt, bitcnt_next;
    logic [7:0] tx, tx_next;
    logic [7:0] rx, rx_next;
    logic [7:0] data_o, data_o_next;
    logic       dsr, dsr_next;
    logic       sclk, sclk_next;
    logic       mosi, mosi_next;
    logic       ss_n, ss_n_next;
    logic       term;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic [7:0] tx_shift(input logic [7:0] d);
        return {1'b0, d[7:1]};
    endfunction
    function automatic logic tx_bit(input logic [7:0] d);
        return d[0];
    endfunction
    function automatic logic [7:0] rx_shift(input logic [7:0] d, input logic b);
        return {b, d[7:1]};
    endfunction
`else
    function automatic logic [7:0] tx_shift(input logic [7:0] d);
        return {d[6:0], 1'b0};
    endfunction
    function automatic logic tx_bit(input logic [7:0] d);
        return d[7];
    endfunction
    function automatic logic [7:0] rx_shift(input logic [7:0] d, input logic b);
        return {d[6:0], b};
    endfunction
`endif

    assign term = (div == DIV_LAST);

    always_comb begin
        state_next  = state;
        div_next    = div;
        bitcnt_next = bitcnt;
        tx_next     = tx;
        rx_next     = rx;
        data_o_next = data_o;
        dsr_next    = dsr;
        sclk_next   = sclk;
        mosi_next   = mosi;
        ss_n_next   = ss_n;
        case (state)
            IDLE: begin
                // Slave select only tracks the core register between transfers.
                ss_n_next = bus.cs_n_i;
                if (bus.wren) begin
                    tx_next     = bus.data_i;
                    mosi_next   = tx_bit(bus.data_i);
                    dsr_next    = 1'b0;
                    div_next    = 8'd0;
                    bitcnt_next = 3'd0;
                    state_next  = LOW;
                end
            end
            LOW: begin
                if (term) begin
                    sclk_next  = 1'b1;
                    rx_next    = rx_shift(rx, bus.miso);
                    div_next   = 8'd0;
                    state_next = HIGH;
                end else begin
                    div_next = div + 8'd1;
                end
            end
            HIGH: begin
                if (term) begin
                    sclk_next = 1'b0;
                    div_next  = 8'd0;
                    if (bitcnt == 3'd7) begin
                        data_o_next = rx;
                        dsr_next    = 1'b1;
                        mosi_next   = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        bitcnt_next = bitcnt + 3'd1;
                        tx_next     = tx_shift(tx);
                        mosi_next   = tx_bit(tx_shift(tx));
                        state_next  = LOW;
                    end
                end else begin
                    div_next = div + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            div    <= 8'd0;
            bitcnt <= 3'd0;
            data_o <= 8'hFF;
            dsr    <= 1'b1;
            sclk   <= 1'b0;
            mosi   <= 1'b1;
            ss_n   <= 1'b1;
        end else begin
            state  <= state_next;
            div    <= div_next;
            bitcnt <= bitcnt_next;
            data_o <= data_o_next;
            dsr    <= dsr_next;
            sclk   <= sclk_next;
            mosi   <= mosi_next;
            ss_n   <= ss_n_next;
        end
    end

    // Shift registers carry data only; their contents are don't-care until loaded.
    always_ff @(posedge clk) begin
        tx <= tx_next;
        rx <= rx_next;
    end

    assign bus.data_o = data_o;
    assign bus.dsr    = dsr;
    assign bus.sclk   = sclk;
    assign bus.mosi   = mosi;
    assign bus.ss_n   = ss_n;
endmodule
